// File: rtl/pad_frame_ctrl.sv
// Pad frame control: registers core->pad controls, synchronises/debounces pad inputs, votes boot straps.
// Latency: outputs to pads 1 cycle; pad input to core SYNC_STAGES+1 cycles (+DEB_CYCLES when debounced).
// Backpressure: none; free-running datapath, strap_valid_o qualifies strap_o once and then holds.
module pad_frame_ctrl #(
    parameter int N_PADS      = 32,
    parameter int CFG_W       = 6,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_W       = 8,
    parameter int DEB_CYCLES  = 16,
    parameter int N_STRAP     = 3,
    parameter int STRAP_DELAY = 64,
    parameter int STRAP_GAP   = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [N_PADS-1:0][CFG_W-1:0]   pad_cfg_i,
    input  logic [N_PADS-1:0]              oe_i,
    input  logic [N_PADS-1:0]              out_i,
    output logic [N_PADS-1:0]              in_o,
    output logic [N_PADS-1:0]              pad_oen_o,
    output logic [N_PADS-1:0]              pad_out_o,
    output logic [N_PADS-1:0]              pad_pen_o,
    input  logic [N_PADS-1:0]              pad_in_i,
    input  logic [N_STRAP-1:0]             strap_pad_i,
    output logic [N_STRAP-1:0]             strap_o,
    output logic                           strap_valid_o
);

    localparam int TCNT_MAX = (STRAP_DELAY > STRAP_GAP) ? STRAP_DELAY : STRAP_GAP;
    localparam int TCNT_W   = $clog2(TCNT_MAX + 1);

    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_ONE    = DEB_W'(1);
    localparam logic [DEB_W-1:0]  DEB_MAX    = {DEB_W{1'b1}};
    localparam logic [TCNT_W-1:0] DELAY_LAST = TCNT_W'(STRAP_DELAY - 1);
    localparam logic [TCNT_W-1:0] GAP_LAST   = TCNT_W'(STRAP_GAP - 1);
    localparam logic [TCNT_W-1:0] TCNT_ONE   = TCNT_W'(1);

    localparam logic [2:0] ST_WAIT    = 3'd0;
    localparam logic [2:0] ST_SAMPLE0 = 3'd1;
    localparam logic [2:0] ST_SAMPLE1 = 3'd2;
    localparam logic [2:0] ST_SAMPLE2 = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    logic [N_PADS-1:0]                   pull_en;
    logic [N_PADS-1:0]                   deb_en;
    logic [SYNC_STAGES-1:0][N_PADS-1:0]  in_sync;
    logic [N_PADS-1:0]                   in_s;
    logic [N_PADS-1:0][DEB_W-1:0]        deb_cnt;

    logic [SYNC_STAGES-1:0][N_STRAP-1:0] strap_sync;
    logic [N_STRAP-1:0]                  strap_s;
    logic [N_STRAP-1:0]                  samp0;
    logic [N_STRAP-1:0]                  samp1;
    logic [N_STRAP-1:0]                  samp2;
    logic [N_STRAP-1:0]                  strap_maj;
    logic [2:0]                          state;
    logic [TCNT_W-1:0]                   tcnt;

    // Reserved config bits are intentionally ignored.
    logic unused_cfg;
    assign unused_cfg = ^pad_cfg_i;

    for (genvar g = 0; g < N_PADS; g++) begin : g_cfg
        assign pull_en[g] = pad_cfg_i[g][0];
        assign deb_en[g]  = pad_cfg_i[g][1];
    end

    assign in_s      = in_sync[SYNC_STAGES-1];
    assign strap_s   = strap_sync[SYNC_STAGES-1];
    assign strap_maj = (samp0 & samp1) | (samp0 & samp2) | (samp1 & samp2);

    // Register the core-side pad controls; pads default to undriven inputs with pulls off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_oen_o <= '1;
            pad_out_o <= '0;
            pad_pen_o <= '1;
        end else begin
            pad_oen_o <= ~oe_i;
            pad_out_o <= out_i;
            pad_pen_o <= ~pull_en;
        end
    end

    // Multi-flop synchronisers for the asynchronous pad and strap inputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_sync    <= '0;
            strap_sync <= '0;
        end else begin
            in_sync    <= {in_sync[SYNC_STAGES-2:0], pad_in_i};
            strap_sync <= {strap_sync[SYNC_STAGES-2:0], strap_pad_i};
        end
    end

    // Per-pad debounce: in_o only follows a level that stayed stable for DEB_CYCLES cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_o    <= '0;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < N_PADS; i++) begin
                if (!deb_en[i]) begin
                    in_o[i]    <= in_s[i];
                    deb_cnt[i] <= '0;
                end else if (in_s[i] == in_o[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    in_o[i]    <= in_s[i];
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] != DEB_MAX) begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_ONE;
                end
            end
        end
    end

    // Strap sequencer: wait after reset, take three spaced samples, publish the majority once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= ST_WAIT;
            tcnt          <= '0;
            samp0         <= '0;
            samp1         <= '0;
            samp2         <= '0;
            strap_o       <= '0;
            strap_valid_o <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (tcnt == DELAY_LAST) begin
                        state <= ST_SAMPLE0;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_ONE;
                    end
                end
                ST_SAMPLE0: begin
                    if (tcnt == '0) begin
                        samp0 <= strap_s;
                    end
                    if (tcnt == GAP_LAST) begin
                        state <= ST_SAMPLE1;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_ONE;
                    end
                end
                ST_SAMPLE1: begin
                    if (tcnt == '0) begin
                        samp1 <= strap_s;
                    end
                    if (tcnt == GAP_LAST) begin
                        state <= ST_SAMPLE2;
                        tcnt  <= '0;
                    end else begin
                        tcnt <= tcnt + TCNT_ONE;
                    end
                end
                ST_SAMPLE2: begin
                    samp2 <= strap_s;
                    state <= ST_DONE;
                    tcnt  <= '0;
                end
                ST_DONE: begin
                    // Result is frozen after the first DONE cycle; straps are ignored from here on.
                    if (!strap_valid_o) begin
                        strap_o       <= strap_maj;
                        strap_valid_o <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_WAIT;
                    tcnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pad_frame_ctrl.sv
// Testbench for pad_frame_ctrl: directed stimulus with scheduled expectations.
// Expectations are queued with a due cycle; monitors compare at the falling edge.
// Strap results are checked when strap_valid_o rises, against a separate queue.
module tb_pad_frame_ctrl;

    localparam int N_PADS  = 32;
    localparam int CFG_W   = 6;
    localparam int N_STRAP = 3;

    logic                         clk_i = 1'b0;
    logic                         rst_ni;
    logic [N_PADS-1:0][CFG_W-1:0] pad_cfg_i;
    logic [N_PADS-1:0]            oe_i;
    logic [N_PADS-1:0]            out_i;
    logic [N_PADS-1:0]            in_o;
    logic [N_PADS-1:0]            pad_oen_o;
    logic [N_PADS-1:0]            pad_out_o;
    logic [N_PADS-1:0]            pad_pen_o;
    logic [N_PADS-1:0]            pad_in_i;
    logic [N_STRAP-1:0]           strap_pad_i;
    logic [N_STRAP-1:0]           strap_o;
    logic                         strap_valid_o;

    pad_frame_ctrl #(
        .N_PADS(N_PADS), .CFG_W(CFG_W), .SYNC_STAGES(2), .DEB_W(8), .DEB_CYCLES(16),
        .N_STRAP(N_STRAP), .STRAP_DELAY(64), .STRAP_GAP(8)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .pad_cfg_i(pad_cfg_i), .oe_i(oe_i), .out_i(out_i),
        .in_o(in_o), .pad_oen_o(pad_oen_o), .pad_out_o(pad_out_o), .pad_pen_o(pad_pen_o),
        .pad_in_i(pad_in_i), .strap_pad_i(strap_pad_i), .strap_o(strap_o),
        .strap_valid_o(strap_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int tcyc = 0;
    int rcyc = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk_i) tcyc <= tcyc + 1;
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rcyc <= 0;
        else         rcyc <= rcyc + 1;
    end

    // sig: 0 in_o[idx], 1 pad_oen_o, 2 pad_out_o, 3 pad_pen_o, 4 strap_o, 5 strap_valid_o, 6 in_o
    typedef struct {
        int          cyc;
        int          sig;
        int          idx;
        logic [31:0] val;
    } exp_t;

    exp_t cq[$];
    exp_t sq[$];
    exp_t s_cur;
    bit   valid_seen = 1'b0;

    function automatic string sig_name(input int s);
        case (s)
            0: return "in_o_bit";
            1: return "pad_oen_o";
            2: return "pad_out_o";
            3: return "pad_pen_o";
            4: return "strap_o";
            5: return "strap_valid_o";
            default: return "in_o";
        endcase
    endfunction

    function automatic void exp_at(input int cyc, input int sig, input int idx, input logic [31:0] val);
        exp_t e;
        e.cyc = cyc; e.sig = sig; e.idx = idx; e.val = val;
        cq.push_back(e);
    endfunction

    function automatic void exp_strap(input int cyc, input logic [31:0] val);
        exp_t e;
        e.cyc = cyc; e.sig = 4; e.idx = 0; e.val = val;
        sq.push_back(e);
    endfunction

    task automatic check_entry(input exp_t e);
        logic [31:0] act;
        case (e.sig)
            0: act = {31'b0, in_o[e.idx]};
            1: act = pad_oen_o;
            2: act = pad_out_o;
            3: act = pad_pen_o;
            4: act = {29'b0, strap_o};
            5: act = {31'b0, strap_valid_o};
            default: act = in_o;
        endcase
        checks++;
        if (e.cyc != tcyc || act !== e.val) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d (due %0d): got %h, expected %h",
                     sig_name(e.sig), e.idx, tcyc, e.cyc, act, e.val);
        end
    endtask

    // Scheduled-expectation monitor.
    initial begin
        forever begin
            @(negedge clk_i);
            for (int i = cq.size() - 1; i >= 0; i--) begin
                if (cq[i].cyc <= tcyc) begin
                    check_entry(cq[i]);
                    cq.delete(i);
                end
            end
        end
    end

    // Strap monitor: compares cycle of the valid rise and the voted value.
    initial begin
        forever begin
            @(negedge clk_i);
            if (strap_valid_o && !valid_seen) begin
                valid_seen = 1'b1;
                if (sq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL strap_valid_rise: unexpected rise at cycle %0d after release", rcyc);
                end else begin
                    s_cur = sq.pop_front();
                    checks += 2;
                    if (rcyc != s_cur.cyc) begin
                        errors++;
                        $display("FAIL strap_valid_cycle: rose at %0d, expected %0d", rcyc, s_cur.cyc);
                    end
                    if ({29'b0, strap_o} !== s_cur.val) begin
                        errors++;
                        $display("FAIL strap_value: got %h, expected %h", strap_o, s_cur.val);
                    end
                end
            end else if (!strap_valid_o) begin
                valid_seen = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_rcyc(input int target);
        int guard = 0;
        while (rcyc != target && guard < 1000) begin
            tick(1);
            guard++;
        end
        if (rcyc != target) begin
            checks++;
            errors++;
            $display("FAIL wait_rcyc: got %0d, expected %0d", rcyc, target);
        end
    endtask

    task automatic check_strap_drained(input string tag);
        checks++;
        if (sq.size() != 0) begin
            errors++;
            $display("FAIL %s: strap_valid_o pending entries %0d, expected 0", tag, sq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic [31:0] pen_exp;

        // Reset with all core controls active to show reset overrides them.
        rst_ni      = 1'b1;
        oe_i        = '1;
        out_i       = '1;
        pad_in_i    = '0;
        strap_pad_i = 3'b101;
        for (int i = 0; i < N_PADS; i++) pad_cfg_i[i] = 6'b000001;
        #1 rst_ni = 1'b0;
        tick(3);
        exp_at(tcyc, 1, 0, 32'hFFFF_FFFF);
        exp_at(tcyc, 2, 0, 32'h0);
        exp_at(tcyc, 3, 0, 32'hFFFF_FFFF);
        exp_at(tcyc, 6, 0, 32'h0);
        exp_at(tcyc, 4, 0, 32'h0);
        exp_at(tcyc, 5, 0, 32'h0);
        oe_i  = '0;
        out_i = '0;
        for (int i = 0; i < N_PADS; i++) pad_cfg_i[i] = 6'b000000;

        // Sequence A: strap 101 held stable.
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_strap(82, 32'h5);
        tick(1);

        // Output path: single pad, registered one cycle later.
        exp_at(tcyc, 1, 0, 32'hFFFF_FFFF);
        oe_i[5]         = 1'b1;
        out_i[5]        = 1'b1;
        pad_cfg_i[5][0] = 1'b1;
        exp_at(tcyc + 1, 1, 0, 32'hFFFF_FFDF);
        exp_at(tcyc + 1, 2, 0, 32'h0000_0020);
        exp_at(tcyc + 1, 3, 0, 32'hFFFF_FFDF);
        tick(1);

        // Output path: mixed pattern, pull on for pads that are multiples of 3.
        oe_i  = 32'hA5A5_0F0F;
        out_i = 32'h1234_5678;
        pen_exp = '1;
        for (int i = 0; i < N_PADS; i++) begin
            pad_cfg_i[i] = (i % 3 == 0) ? 6'b000001 : 6'b111110;
            if (i % 3 == 0) pen_exp[i] = 1'b0;
        end
        exp_at(tcyc + 1, 1, 0, 32'h5A5A_F0F0);
        exp_at(tcyc + 1, 2, 0, 32'h1234_5678);
        exp_at(tcyc + 1, 3, 0, pen_exp);
        tick(1);
        pad_cfg_i[3] = 6'b000000;
        pad_cfg_i[7] = 6'b000010;
        tick(2);

        // Non-debounced pad 3: 3-cycle latency both directions.
        pad_in_i[3] = 1'b1;
        exp_at(tcyc + 2, 0, 3, 32'h0);
        exp_at(tcyc + 3, 0, 3, 32'h1);
        tick(6);
        pad_in_i[3] = 1'b0;
        exp_at(tcyc + 2, 0, 3, 32'h1);
        exp_at(tcyc + 3, 0, 3, 32'h0);
        tick(6);

        // Debounced pad 7: 10-cycle glitch is filtered.
        k = tcyc;
        pad_in_i[7] = 1'b1;
        exp_at(k + 12, 0, 7, 32'h0);
        exp_at(k + 18, 0, 7, 32'h0);
        exp_at(k + 25, 0, 7, 32'h0);
        tick(10);
        pad_in_i[7] = 1'b0;
        tick(20);

        // Debounced pad 7: 20-cycle pulse rises at +18, falls 18 after release.
        k = tcyc;
        pad_in_i[7] = 1'b1;
        exp_at(k + 17, 0, 7, 32'h0);
        exp_at(k + 18, 0, 7, 32'h1);
        tick(20);
        pad_in_i[7] = 1'b0;
        exp_at(k + 37, 0, 7, 32'h1);
        exp_at(k + 38, 0, 7, 32'h0);
        tick(25);

        // Clearing debounce mid-count makes the pad follow the synchroniser next cycle.
        k = tcyc;
        pad_in_i[7] = 1'b1;
        tick(5);
        pad_cfg_i[7][1] = 1'b0;
        exp_at(k + 5, 0, 7, 32'h0);
        exp_at(k + 6, 0, 7, 32'h1);
        tick(3);

        // Straps ignore later pad changes.
        if (rcyc < 90) wait_rcyc(90);
        strap_pad_i = 3'b010;
        tick(10);
        exp_at(tcyc, 4, 0, 32'h5);
        exp_at(tcyc, 5, 0, 32'h1);
        tick(2);
        check_strap_drained("strap_seq_a");

        // Sequence B: asynchronous reset at cycle 70 of the strap sequence.
        oe_i        = '1;
        pad_in_i[3] = 1'b1;
        strap_pad_i = 3'b111;
        @(negedge clk_i);
        rst_ni = 1'b0;
        tick(2);
        @(negedge clk_i);
        rst_ni = 1'b1;
        wait_rcyc(69);
        exp_at(tcyc, 1, 0, 32'h0);
        exp_at(tcyc, 0, 3, 32'h1);
        exp_at(tcyc, 5, 0, 32'h0);
        tick(1);
        #1 rst_ni = 1'b0;
        exp_at(tcyc, 1, 0, 32'hFFFF_FFFF);
        exp_at(tcyc, 2, 0, 32'h0);
        exp_at(tcyc, 3, 0, 32'hFFFF_FFFF);
        exp_at(tcyc, 0, 3, 32'h0);
        exp_at(tcyc, 5, 0, 32'h0);
        tick(2);

        // Sequence C: majority vote with per-bit disagreement across samples.
        strap_pad_i = 3'b001;
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_strap(82, 32'h1);
        wait_rcyc(66);
        strap_pad_i = 3'b010;
        wait_rcyc(76);
        strap_pad_i = 3'b101;
        wait_rcyc(90);
        strap_pad_i = 3'b110;
        tick(10);
        exp_at(tcyc, 4, 0, 32'h1);
        exp_at(tcyc, 5, 0, 32'h1);
        tick(2);
        check_strap_drained("strap_seq_c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
